instr_queue_decode: RTL
=======================

// Module: instr_queue_decode
// PURPOSE
//  Receiving end of the dual-issue fetch-to-decode packet interface. Buffers pairs of 66-bit fetch
//  packets ({hit, predBJ, pc, instr}) in a FIFO and presents the head pair to decode as slots D1/D2.
//  Pre-decodes JAL/BRANCH per slot and drives the branch-resolution feedback (hit/predBJ/isBJ/realBJ/
//  pc/targetPC _D1/_D2) back to the fetch-stage branch predictor. Absorbs fetch/decode rate mismatch.
// PARAMETERS
//  width  32  data/PC width
//  DEPTH  8   queue capacity in packet PAIRS; power of two, >= 2
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      synchronous, active-high
//  buffIn_D1     in   66     fetch packet slot 1: [65]hit [64]predBJ [63:32]pc [31:0]instr
//  buffIn_D2     in   66     fetch packet slot 2, same layout
//  valid_F       in   1      fetch presents a pair this cycle
//  stall_F       out  1      queue full; fetch must hold its pair
//  stall_D       in   1      decode cannot accept the head pair
//  flush_D1F     in   1      predictor redirect caused by slot 1
//  flush_D2F     in   1      predictor redirect caused by slot 2
//  cmpTaken_D1   in   1      decode comparator outcome for slot-1 branch
//  cmpTaken_D2   in   1      decode comparator outcome for slot-2 branch
//  valid_D1      out  1      slot 1 holds a live instruction
//  valid_D2      out  1      slot 2 holds a live instruction
//  instr_D1/_D2  out  width  instruction words
//  hit_D1/_D2, predBJ_D1/_D2, isBJ_D1/_D2, realBJ_D1/_D2  out 1 each   predictor feedback
//  pc_D1/_D2, targetPC_D1/_D2                            out width each  predictor feedback
// BEHAVIOUR
//  - Storage: DEPTH x 132-bit pair entries; wr_ptr/rd_ptr log2(DEPTH) bits, wrap modulo DEPTH;
//    count log2(DEPTH)+1 bits.
//  - Reset: pointers/count = 0; every output = 0 (stall_F = 0, valid_D* = 0).
//  - stall_F = (count == DEPTH). Registered-count based: no enqueue when full, even with a
//    same-cycle dequeue.
//  - Enqueue at edge when valid_F & !stall_F & !flush. Dequeue when count != 0 & !stall_D & !flush.
//    Simultaneous enqueue+dequeue leaves count unchanged.
//  - Latency: a pair enqueued at edge N appears on the outputs in cycle N+1.
//  - flush = flush_D1F | flush_D2F. At the edge: pointers and count -> 0; incoming pair dropped
//    (wrong path). Flush beats enqueue/dequeue. Flush with reset: reset wins (identical result).
//  - Pre-decode (combinational from head):
//    - opcode 1101111 (JAL): isBJ = 1, realBJ = 1, target = pc + sext(J-imm).
//    - opcode 1100011 (BRANCH): isBJ = 1, realBJ = cmpTaken, target = pc + sext(B-imm).
//    - Otherwise (incl. JALR): isBJ = 0, realBJ = 0, target = pc + 4.
//    - Adds wrap modulo 2^width.
//  - valid_D1 = (count != 0).
//    valid_D2 = valid_D1 & !predBJ_D1 & !realBJ_D1 (slot 2 is wrong path when slot 1 redirects).
//  - An invalid slot drives all its feedback/instr outputs to 0. cmpTaken->realBJ is a
//    combinational path.
// CONFIGURATION
//  - IQ_BYPASS_EN defined: when count == 0 & valid_F & !flush, buffIn_D1/_D2 drive the outputs
//    the same cycle (0-cycle latency).
//    - stall_D = 0: the pair is consumed and not written.
//    - stall_D = 1: the pair is written.
//  - IQ_BYPASS_EN undefined: no bypass; minimum latency 1 cycle.
// STRUCTURE
//  - Package fetch_pkg: PKT_W = 66; field offsets HIT_B = 65, PRED_B = 64, PC_HI/LO, INSTR_HI/LO;
//    OPC_JAL, OPC_BRANCH; typedef fetch_pkt_t.
//  - Sub-module bj_predecode (pc, instr, cmpTaken -> isBJ, realBJ, targetPC); instantiated twice.
// TESTING
//  1. reset high 2 cycles, valid_F = 1 -> stall_F = 0, valid_D1 = valid_D2 = 0, all feedback 0.
//  2. stall_D = 1, valid_F every cycle, DEPTH = 8 -> stall_F = 1 after 8th enqueue, 9th pair held.
//     Release stall_D -> pairs emerge in order, one per cycle.
//  3. D1 = {0,0,32'h100,32'h1000006F} -> isBJ_D1 = 1, realBJ_D1 = 1, targetPC_D1 = 32'h200,
//     valid_D2 = 0.
//  4. D1 = {1,0,32'h40,32'hFE000CE3}, cmpTaken_D1 = 0 -> isBJ_D1 = 1, realBJ_D1 = 0,
//     targetPC_D1 = 32'h38, valid_D2 = 1. With cmpTaken_D1 = 1 -> realBJ_D1 = 1, valid_D2 = 0.
//  5. 3 pairs queued, flush_D1F = 1 with valid_F = 1 -> next cycle valid_D1 = 0, stall_F = 0,
//     new pair dropped.
//  6. IQ_BYPASS_EN, empty queue, valid_F = 1, stall_D = 0 -> valid_D1 = 1 and pc_D1 = buffIn pc
//     same cycle; queue stays empty.

Source files
------------

// File: rtl/fetch_pkg.sv
// Fetch-to-decode packet definitions shared by the instruction queue and its pre-decoder.
// A fetch packet is 66 bits: [65] hit, [64] predBJ, [63:32] pc, [31:0] instr.
package fetch_pkg;

  localparam int unsigned PKT_W    = 66;
  localparam int unsigned HIT_B    = 65;
  localparam int unsigned PRED_B   = 64;
  localparam int unsigned PC_HI    = 63;
  localparam int unsigned PC_LO    = 32;
  localparam int unsigned INSTR_HI = 31;
  localparam int unsigned INSTR_LO = 0;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Field order matches the bit layout above (first member is the MSB).
  typedef struct packed {
    logic        hit;
    logic        pred_bj;
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/bj_predecode.sv
// Pre-decodes one slot for JAL / conditional BRANCH and computes the resolved target.
// Ports:
//   pc       in   width  slot PC
//   instr    in   32     slot instruction word
//   cmpTaken in   1      decode comparator outcome (only meaningful for BRANCH)
//   isBJ     out  1      instruction is JAL or BRANCH
//   realBJ   out  1      instruction actually redirects (JAL always, BRANCH when taken)
//   targetPC out  width  pc + J/B immediate, or pc + 4 for everything else (incl. JALR)
module bj_predecode
  import fetch_pkg::*;
#(
  parameter int unsigned width = 32
) (
  input  logic [width-1:0] pc,
  input  logic [31:0]      instr,
  input  logic             cmpTaken,
  output logic             isBJ,
  output logic             realBJ,
  output logic [width-1:0] targetPC
);

  localparam logic [width-1:0] Four = width'(4);

  logic [6:0]       opcode;
  logic [width-1:0] j_imm;
  logic [width-1:0] b_imm;

  assign opcode = instr[6:0];

  // J-imm is 21 bits and B-imm 13 bits before sign extension; bit 0 is always zero.
  assign j_imm = {{(width - 20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign b_imm = {{(width - 12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

  always_comb begin
    isBJ     = 1'b0;
    realBJ   = 1'b0;
    targetPC = pc + Four;
    case (opcode)
      OPC_JAL: begin
        isBJ     = 1'b1;
        realBJ   = 1'b1;
        targetPC = pc + j_imm;
      end
      OPC_BRANCH: begin
        isBJ     = 1'b1;
        realBJ   = cmpTaken;
        targetPC = pc + b_imm;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/instr_queue_decode.sv
// Receiving end of the dual-issue fetch-to-decode interface. Buffers pairs of fetch packets in
// a FIFO of DEPTH pair entries and presents the head pair to decode as slots D1/D2, together with
// the branch-resolution feedback for the fetch-stage predictor.
// Optional feature macro: IQ_BYPASS_EN -- when the queue is empty, an incoming pair is shown on
// the outputs in the same cycle (consumed directly if decode is not stalled).
// Ports:
//   clk, reset (sync, active-high)
//   buffIn_D1/_D2, valid_F       fetch pair in; stall_F out = queue full
//   stall_D                      decode cannot accept the head pair
//   flush_D1F/_D2F               predictor redirect: empty the queue, drop incoming pair
//   cmpTaken_D1/_D2              branch comparator outcomes from decode
//   valid_D1/_D2, instr_D*       slot contents
//   hit/predBJ/isBJ/realBJ/pc/targetPC _D1/_D2   predictor feedback (zero for invalid slots)
module instr_queue_decode
  import fetch_pkg::*;
#(
  parameter int unsigned width = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PKT_W-1:0] buffIn_D1,
  input  logic [PKT_W-1:0] buffIn_D2,
  input  logic             valid_F,
  output logic             stall_F,
  input  logic             stall_D,
  input  logic             flush_D1F,
  input  logic             flush_D2F,
  input  logic             cmpTaken_D1,
  input  logic             cmpTaken_D2,
  output logic             valid_D1,
  output logic             valid_D2,
  output logic [width-1:0] instr_D1,
  output logic [width-1:0] instr_D2,
  output logic             hit_D1,
  output logic             hit_D2,
  output logic             predBJ_D1,
  output logic             predBJ_D2,
  output logic             isBJ_D1,
  output logic             isBJ_D2,
  output logic             realBJ_D1,
  output logic             realBJ_D2,
  output logic [width-1:0] pc_D1,
  output logic [width-1:0] pc_D2,
  output logic [width-1:0] targetPC_D1,
  output logic [width-1:0] targetPC_D2
);

  localparam int unsigned        PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0]      Full = (PtrW + 1)'(DEPTH);

  // Each entry holds {slot 2, slot 1}.
  logic [2*PKT_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q, count_d;

  logic flush, empty, full, bypass, enq, deq;
  logic [2*PKT_W-1:0] head_pair;
  fetch_pkt_t         hd1, hd2;
  logic               head_valid, slot1_valid, slot2_valid;
  logic               isbj1, isbj2, realbj1, realbj2;
  logic [width-1:0]   tgt1, tgt2;

  assign flush = flush_D1F | flush_D2F;
  assign empty = (count_q == '0);
  assign full  = (count_q == Full);

`ifdef IQ_BYPASS_EN
  // Reset is folded in so every output stays zero while reset is held.
  assign bypass = empty & valid_F & ~flush & ~reset;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair that decode accepts immediately must not also be stored.
  assign enq = valid_F & ~full & ~flush & ~(bypass & ~stall_D);
  assign deq = ~empty & ~stall_D & ~flush;

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (enq && !reset) mem_q[wr_ptr_q] <= {buffIn_D2, buffIn_D1};
  end

  assign head_pair  = bypass ? {buffIn_D2, buffIn_D1} : mem_q[rd_ptr_q];
  assign hd1        = fetch_pkt_t'(head_pair[PKT_W-1:0]);
  assign hd2        = fetch_pkt_t'(head_pair[2*PKT_W-1:PKT_W]);
  assign head_valid = ~empty | bypass;

  bj_predecode #(
    .width(width)
  ) u_pd1 (
    .pc      (hd1.pc),
    .instr   (hd1.instr),
    .cmpTaken(cmpTaken_D1),
    .isBJ    (isbj1),
    .realBJ  (realbj1),
    .targetPC(tgt1)
  );

  bj_predecode #(
    .width(width)
  ) u_pd2 (
    .pc      (hd2.pc),
    .instr   (hd2.instr),
    .cmpTaken(cmpTaken_D2),
    .isBJ    (isbj2),
    .realBJ  (realbj2),
    .targetPC(tgt2)
  );

  // Slot 2 is wrong-path whenever slot 1 is predicted or resolved to redirect.
  assign slot1_valid = head_valid;
  assign slot2_valid = slot1_valid & ~hd1.pred_bj & ~realbj1;

  assign stall_F = full;

  assign valid_D1    = slot1_valid;
  assign instr_D1    = slot1_valid ? hd1.instr : '0;
  assign hit_D1      = slot1_valid & hd1.hit;
  assign predBJ_D1   = slot1_valid & hd1.pred_bj;
  assign isBJ_D1     = slot1_valid & isbj1;
  assign realBJ_D1   = slot1_valid & realbj1;
  assign pc_D1       = slot1_valid ? hd1.pc : '0;
  assign targetPC_D1 = slot1_valid ? tgt1 : '0;

  assign valid_D2    = slot2_valid;
  assign instr_D2    = slot2_valid ? hd2.instr : '0;
  assign hit_D2      = slot2_valid & hd2.hit;
  assign predBJ_D2   = slot2_valid & hd2.pred_bj;
  assign isBJ_D2     = slot2_valid & isbj2;
  assign realBJ_D2   = slot2_valid & realbj2;
  assign pc_D2       = slot2_valid ? hd2.pc : '0;
  assign targetPC_D2 = slot2_valid ? tgt2 : '0;

endmodule
